pop_count_arbiter: RTL and testbench
====================================

# pop_count_arbiter

Round-robin arbiter and pipeline sequencer that shares one 32-bit population-count unit (`pop_count_no_scheme`, 32-bit in, 6-bit out) among `N_REQ` requesters. Each requester offers a 32-bit word through a valid/ready handshake. The block registers the granted word and computes the popcount combinationally, then registers the result. It returns the count, tagged with the requester index, through a single valid/ready response port. It sits between the requesting datapaths and the popcount unit and replaces the fixed input/output register wrapper when more than one client needs the unit.

## Interface
- `N_REQ`, default 4, number of requesters (2..16).
- `ID_W`, default `$clog2(N_REQ)`, width of the requester tag. Derived; do not override.
- `clk`, input, 1, single clock, rising edge.
- `rst`, input, 1. Reset is synchronous and active-high.
- `req_valid`, input, `N_REQ`. Bit i: requester i offers a word.
- `req_data`, input, `32*N_REQ`. Requester i word is at bits `[32*i+31 : 32*i]`.
- `req_ready`, output, `N_REQ`. Bit i: word i is accepted this cycle. One-hot or zero.
- `rsp_valid`, output, 1. Result is available.
- `rsp_id`, output, `ID_W`. Index of the requester that owns the result.
- `rsp_count`, output, 6. Popcount of that requester's word, range 0..32.
- `rsp_ready`, input, 1. Consumer accepts the result.

## Operation
- Pipeline:
  - Stage A holds `a_valid`, `a_id` and `a_data` (32 bits).
  - The popcount unit is driven from `a_data`.
  - Stage B holds `rsp_valid`, `rsp_id` and `rsp_count`, all registered.
- Advance rules:
  - `b_free = !rsp_valid | rsp_ready`.
  - `a_free = !a_valid | b_free`.
  - Stage B loads from stage A when `b_free`. B's valid becomes `a_valid`.
  - Stage A loads the granted request when `a_free`. A's valid becomes "any transfer this cycle".
- Arbitration is combinational round-robin:
  - Priority pointer `ptr` (`ID_W` bits).
  - Winner = first i with `req_valid[i]`, searching `ptr, ptr+1, ... , N_REQ-1, 0, ...` (wrap modulo `N_REQ`).
  - `req_ready[i] = a_free & (winner == i) & req_valid[i]`.
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`. Requesters must not make `req_valid` depend on `req_ready`.
- Pointer update:
  - On a transfer from i, `ptr <= (i+1) mod N_REQ`.
  - With no transfer, `ptr` holds.
  - When `N_REQ` is not a power of two, wrap explicitly; `ptr` never holds a value ≥ `N_REQ`.
- Request rules:
  - A requester with `req_valid` high keeps `req_data` stable until its `req_ready`.
  - `req_valid` is not retracted before acceptance.
- Response rules: while `rsp_valid & !rsp_ready`, `rsp_id` and `rsp_count` hold stable.
- Width rule: `rsp_count` = sum of the 32 bits. 32 = 6'b100000; no saturation or overflow is possible.
- Results leave in acceptance order; the pipeline never reorders or drops a result.

## Timing
- Reset (sync, `rst` high at a rising edge):
  - `a_valid = 0`, `rsp_valid = 0`, `rsp_id = 0`, `rsp_count = 0`, `ptr = 0`.
  - `req_ready` is 0 while `rst` is high.
- Reset mid-operation: in-flight words in A and B are discarded, with no response. `rsp_valid` is 0 in the cycle after the reset edge.
- Latency: a word accepted in cycle c has `rsp_valid` high in cycle c+2, provided `rsp_ready` was not stalling.
- Throughput: one word per cycle with `rsp_ready` held high.
- Backpressure with `rsp_ready` low:
  - B holds.
  - A fills at most one more word.
  - `req_ready` then drops to 0 in the following cycle.
  - When `rsp_ready` rises, B takes A and A takes a new request in the same cycle: no bubble.
- Simultaneous requests: exactly one grant per cycle. Losers keep `req_valid` and are served in pointer order.
- Idle (no `req_valid`): A empties, `ptr` is unchanged, and no spurious `rsp_valid` occurs.

## Test plan
- Single requester, `N_REQ`=4. Requester 2 sends 32'hFFFFFFFF in cycle 5, then 32'h0 in cycle 6; `rsp_ready`=1.
  - Cycle 7: `rsp_valid`=1, `rsp_id`=2, `rsp_count`=32.
  - Cycle 8: `rsp_count`=0.
- All four requesters hold `req_valid` continuously with data 32'h1, 32'h3, 32'h7, 32'hF.
  - Grants follow 0,1,2,3,0,1…, one per cycle.
  - Responses show counts 1,2,3,4 repeating.
- Backpressure: stream from requester 0 with `rsp_ready` low for 4 cycles.
  - `rsp_valid` is held with stable id/count.
  - `req_ready` is 0 after A fills.
  - After release, all words arrive in order; none is lost or duplicated.
- Fairness: requester 3 alone is granted. Next cycle requesters 0 and 3 are both valid.
  - Requester 0 is granted (`ptr`=0 after the wrap), then requester 3.
- Reset mid-flight: assert `rst` for one cycle while A and B are both valid.
  - Next cycle `rsp_valid`=0 and `ptr`=0.
  - Those words never appear at the response port.
- Random: random valids, data and `rsp_ready` for 10k cycles.
  - Scoreboard the per-requester count against a reference popcount.
  - Check acceptance order against response order.
  - Check no requester waits more than `N_REQ` grants while valid and unstalled.

Source files
------------

// File: rtl/pop_count_arbiter.sv
// Round-robin arbiter sharing one 32-bit popcount stage among N_REQ requesters.
// Two-stage pipeline (A: operand, B: result) with valid/ready on both sides.
module pop_count_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [32*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  rsp_valid,
  output logic [ID_W-1:0]       rsp_id,
  output logic [5:0]            rsp_count,
  input  logic                  rsp_ready
);

  logic            a_valid;
  logic [ID_W-1:0] a_id;
  logic [31:0]     a_data;
  logic [ID_W-1:0] ptr;

  logic            b_free;
  logic            a_free;
  logic            found;
  logic [ID_W-1:0] winner;
  logic [ID_W-1:0] cand;
  logic [31:0]     grant_data;
  logic            transfer;
  logic [5:0]      pc;

  assign b_free   = !rsp_valid || rsp_ready;
  assign a_free   = !a_valid || b_free;
  assign transfer = |req_ready;

  // Walk the requesters starting at ptr, wrapping explicitly so non-power-of-two
  // N_REQ never produces an out-of-range candidate.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = ptr;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
      cand = (cand == ID_W'(N_REQ - 1)) ? '0 : cand + 1'b1;
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && a_free && found)
      req_ready[winner] = 1'b1;
  end

  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (winner == ID_W'(i))
        grant_data = req_data[32*i +: 32];
    end
  end

  always_comb begin
    pc = '0;
    for (int unsigned i = 0; i < 32; i++)
      pc = pc + {5'b0, a_data[i]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid   <= 1'b0;
      a_id      <= '0;
      a_data    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_count <= '0;
      ptr       <= '0;
    end else begin
      if (b_free) begin
        rsp_valid <= a_valid;
        if (a_valid) begin
          rsp_id    <= a_id;
          rsp_count <= pc;
        end
      end
      if (a_free) begin
        a_valid <= transfer;
        if (transfer) begin
          a_id   <= winner;
          a_data <= grant_data;
        end
      end
      if (transfer)
        ptr <= (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
    end
  end

endmodule

// File: tb/tb_pop_count_arbiter.sv
// Directed and short randomized checks for pop_count_arbiter (N_REQ = 4).
module tb_pop_count_arbiter;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [32*N-1:0]  req_data;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic [1:0]       rsp_id;
  logic [5:0]       rsp_count;
  logic             rsp_ready;

  int errors = 0;
  int checks = 0;

  int qid[$];
  int qcnt[$];
  int waits[N];
  logic [N-1:0] acc;

  always #5 clk = ~clk;

  pop_count_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_count(rsp_count),
    .rsp_ready(rsp_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    req_data[32*i +: 32] = w;
  endtask

  function automatic logic [31:0] ones(input int c);
    return 32'hFFFF_FFFF >> (32 - c);
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired before completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = '0; req_data = '0; rsp_ready = 1'b1;
    tick; tick;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_count", rsp_count, 0);
    chk("rst_ptr", dut.ptr, 0);
    chk("rst_a_valid", dut.a_valid, 0);
    req_valid = '1; #1;
    chk("rst_ready", req_ready, 0);
    req_valid = '0; rst = 1'b0;
    tick;

    // single requester: full word then zero word
    set_word(2, 32'hFFFF_FFFF); req_valid = 4'b0100; #1;
    chk("single_ready0", req_ready, 4'b0100);
    tick;
    set_word(2, 32'h0); #1;
    chk("single_ready1", req_ready, 4'b0100);
    tick;
    chk("single_valid0", rsp_valid, 1);
    chk("single_id0", rsp_id, 2);
    chk("single_count32", rsp_count, 32);
    req_valid = '0;
    tick;
    chk("single_valid1", rsp_valid, 1);
    chk("single_id1", rsp_id, 2);
    chk("single_count0", rsp_count, 0);
    tick;
    chk("idle_valid", rsp_valid, 0);
    chk("ptr_after_2", dut.ptr, 3);

    // fairness: 3 alone, then 0 and 3 together
    set_word(0, 32'h1); set_word(1, 32'h3); set_word(2, 32'h7); set_word(3, 32'hF);
    req_valid = 4'b1000; #1;
    chk("fair_g3", req_ready, 4'b1000);
    tick;
    req_valid = 4'b1001; #1;
    chk("fair_g0", req_ready, 4'b0001);
    tick;
    chk("fair_rsp3_id", rsp_id, 3);
    chk("fair_rsp3_cnt", rsp_count, 4);
    req_valid = 4'b1000; #1;
    chk("fair_g3b", req_ready, 4'b1000);
    tick;
    chk("fair_rsp0_id", rsp_id, 0);
    chk("fair_rsp0_cnt", rsp_count, 1);
    req_valid = '0;
    tick;
    chk("fair_rsp3b_id", rsp_id, 3);
    chk("fair_rsp3b_cnt", rsp_count, 4);
    chk("fair_ptr", dut.ptr, 0);
    tick;

    // round robin with all four valid
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("rr_grant", req_ready, 32'(1 << (k % 4)));
      tick;
      if (k > 0) begin
        chk("rr_id", rsp_id, 32'((k - 1) % 4));
        chk("rr_count", rsp_count, 32'((k - 1) % 4 + 1));
      end
    end
    req_valid = '0;
    tick;
    chk("rr_last_id", rsp_id, 3);
    chk("rr_last_count", rsp_count, 4);
    tick;
    chk("rr_idle", rsp_valid, 0);

    // backpressure on a stream from requester 0
    set_word(0, ones(5)); req_valid = 4'b0001; #1;
    chk("bp_g0", req_ready, 4'b0001);
    tick;
    rsp_ready = 1'b0; set_word(0, ones(6)); #1;
    chk("bp_fill", req_ready, 4'b0001);
    tick;
    set_word(0, ones(7));
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("bp_ready_low", req_ready, 0);
      chk("bp_hold_valid", rsp_valid, 1);
      chk("bp_hold_count", rsp_count, 5);
      chk("bp_hold_id", rsp_id, 0);
      tick;
    end
    rsp_ready = 1'b1; #1;
    chk("bp_nobubble", req_ready, 4'b0001);
    tick;
    chk("bp_c6", rsp_count, 6);
    set_word(0, ones(8));
    tick;
    chk("bp_c7", rsp_count, 7);
    req_valid = '0;
    tick;
    chk("bp_c8", rsp_count, 8);
    chk("bp_c8_valid", rsp_valid, 1);
    tick;
    chk("bp_drained", rsp_valid, 0);

    // reset while A and B are both occupied
    set_word(1, 32'h0000_FFFF); req_valid = 4'b0010;
    tick;
    set_word(2, 32'hF0F0_F0F0); req_valid = 4'b0100;
    tick;
    chk("mid_pre_b", rsp_valid, 1);
    chk("mid_pre_a", dut.a_valid, 1);
    rst = 1'b1; #1;
    chk("mid_rst_ready", req_ready, 0);
    tick;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_ptr", dut.ptr, 0);
    chk("mid_a_valid", dut.a_valid, 0);
    rst = 1'b0; req_valid = '0;
    tick;
    chk("mid_lost0", rsp_valid, 0);
    tick;
    chk("mid_lost1", rsp_valid, 0);

    // randomized traffic against an in-order scoreboard
    for (int i = 0; i < N; i++) waits[i] = 0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_word(i, $urandom);
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      chk("rnd_onehot", 32'($onehot0(req_ready)), 1);
      if (rsp_valid && rsp_ready) begin
        if (qid.size() == 0) begin
          chk("rnd_spurious", 1, 0);
        end else begin
          chk("rnd_id", rsp_id, qid.pop_front());
          chk("rnd_count", rsp_count, qcnt.pop_front());
        end
      end
      acc = req_ready;
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          qid.push_back(i);
          qcnt.push_back($countones(req_data[32*i +: 32]));
          chk("rnd_wait", 32'(waits[i] <= N - 1), 1);
          waits[i] = 0;
          for (int j = 0; j < N; j++)
            if (j != i && req_valid[j]) waits[j]++;
        end
      end
      tick;
      req_valid = req_valid & ~acc;
    end
    req_valid = '0; rsp_ready = 1'b1;
    for (int d = 0; d < 10; d++) begin
      #1;
      if (rsp_valid) begin
        if (qid.size() == 0) begin
          chk("drain_spurious", 1, 0);
        end else begin
          chk("drain_id", rsp_id, qid.pop_front());
          chk("drain_count", rsp_count, qcnt.pop_front());
        end
      end
      tick;
    end
    chk("drain_empty", qid.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
